ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
// - Central hazard controller for the 5-stage pipeline, wrapped around the execute stage.
// - Generates forwarding selects for the E-stage source muxes.
// - Generates stall and flush controls for the F/D/E/M pipeline registers.
// - Sequences a shared iterative mul/div unit in E: start pulse, hold pipeline until done, timeout.
// PARAMETERS
// - MD_TIMEOUT  64  max BUSY cycles before abort; >=2, counter width $clog2(MD_TIMEOUT)+1
// PORTS
// - clk            in   1   pipeline clock, rising edge
// - rst            in   1   asynchronous, active-high reset
// - Rs1D_i, Rs2D_i in   5   source regs of instr in D
// - Rs1E_i, Rs2E_i in   5   source regs of instr in E
// - RdE_i          in   5   dest reg of instr in E
// - RdM_i          in   5   dest reg of instr in M
// - RdW_i          in   5   dest reg of instr in W
// - RegWriteM_i    in   1   instr in M writes the regfile
// - RegWriteW_i    in   1   instr in W writes the regfile
// - LoadE_i        in   1   instr in E is a load (ResultSrc = memory)
// - PCSrcE_i       in   2   E-stage PC select; !=2'b00 = taken branch/jump
// - MulDivE_i      in   1   instr in E needs the mul/div unit
// - MulDivDone_i   in   1   mul/div result valid (single-cycle pulse)
// - ForwardAE_o    out  2   00 RD1E, 01 ResultW, 10 ALUResultM
// - ForwardBE_o    out  2   same encoding for RD2E
// - StallF_o, StallD_o, StallE_o  out 1 each  hold PC / D reg / E reg
// - FlushD_o, FlushE_o, FlushM_o  out 1 each  bubble into D / E / M reg
// - MulDivStart_o  out  1   one-cycle start pulse to mul/div unit
// - Busy_o         out  1   registered; FSM in BUSY
// - TimeoutErr_o   out  1   registered, sticky until reset
// BEHAVIOUR
// - Reset (async): state=IDLE, count=0, Busy_o=0, TimeoutErr_o=0, counters=0.
//   All combinational outputs settle to 0 when no hazard is present.
// - Forwarding (combinational), per source s in {Rs1E, Rs2E}:
//   - s!=0 && RegWriteM_i && s==RdM_i -> 10;
//   - else s!=0 && RegWriteW_i && s==RdW_i -> 01;
//   - else 00. M wins over W. x0 is never forwarded.
// - Load-use: lwStall = LoadE_i && RdE_i!=0 && (Rs1D_i==RdE_i || Rs2D_i==RdE_i).
//   - Drives StallF, StallD and FlushE.
//   - Exactly 1 cycle, because the load advances to M next edge.
// - Control flow: PCSrcE_i!=0 -> FlushD=1, FlushE=1 in the same cycle.
//   - FlushE from a branch overrides lwStall (a load cannot be in E with a branch, so no loss).
// - Mul/div FSM, states IDLE, BUSY:
//   - IDLE & MulDivE_i -> MulDivStart_o=1 (comb), StallF/D/E=1, FlushM=1. Next state BUSY, count=0.
//   - BUSY & !MulDivDone_i -> StallF/D/E=1, FlushM=1, count++.
//   - BUSY & MulDivDone_i -> stalls released this cycle; E advances at this edge with the result. Next state IDLE.
//   - BUSY & count==MD_TIMEOUT-1 & !done -> TimeoutErr_o<=1, next IDLE, stalls released.
//   - Start is never reissued while BUSY, and only one start is issued per E instruction.
// - Priority:
//   - Mul/div stall (IDLE-start or BUSY) dominates lwStall; FlushE is forced 0 while E is held.
//   - Done and timeout in the same cycle: done wins, no error.
// - Reset mid-BUSY: immediate IDLE. MulDivStart_o=0, all stalls drop and count clears asynchronously.
// CONFIGURATION
// - Macro HAZARD_PERF_CNT_EN.
// - Defined: adds output ports StallCycles_o[31:0] and FlushCount_o[31:0].
//   - StallCycles_o: +1 each cycle StallF_o=1.
//   - FlushCount_o: +1 each cycle PCSrcE_i!=0.
//   - Both saturate at 32'hFFFF_FFFF and reset to 0.
// - Undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
// - RdM=5, RegWriteM=1, Rs1E=5; RdW=5, RegWriteW=1 -> ForwardAE=10. Same with Rs1E=0 -> 00.
// - LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle all 0.
// - PCSrcE=01 with LoadE/Rs match also set -> FlushD=FlushE=1 and StallF=0.
// - MulDivE=1 and Done arriving 5 cycles after start:
//   - MulDivStart_o pulses once; StallE=1 for 5 cycles then 0.
//   - Busy_o high 5 cycles; TimeoutErr_o=0.
// - MD_TIMEOUT=8, Done never asserted -> TimeoutErr_o=1 after 8 BUSY cycles, FSM IDLE, stalls 0.
// - Assert rst for 1 cycle at BUSY cycle 3 -> Busy_o=0 and stalls 0 immediately; no start pulse until MulDivE re-seen.

Source files
------------

// File: rtl/ex_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_hazard_ctrl_if
// Description : Signal bundle between the pipeline datapath and the hazard
//               controller that sits around the execute stage.
//               slave  : hazard controller side (consumes register ids and
//                        stage status, produces forward/stall/flush controls).
//               master : pipeline side (drives ids/status, consumes controls).
// Signals     : Rs1D_i, Rs2D_i       [4:0] source regs of instr in D
//               Rs1E_i, Rs2E_i       [4:0] source regs of instr in E
//               RdE_i, RdM_i, RdW_i  [4:0] dest regs of instr in E / M / W
//               RegWriteM_i, RegWriteW_i   M / W instr writes the regfile
//               LoadE_i                    E instr is a load
//               PCSrcE_i             [1:0] E-stage PC select, !=0 = taken
//               MulDivE_i                  E instr needs the mul/div unit
//               MulDivDone_i               mul/div result valid pulse
//               ForwardAE_o, ForwardBE_o [1:0] E source mux selects
//               StallF_o, StallD_o, StallE_o   pipeline register holds
//               FlushD_o, FlushE_o, FlushM_o   pipeline register bubbles
//               MulDivStart_o              start pulse to mul/div unit
//               Busy_o                     mul/div sequencer busy (registered)
//               TimeoutErr_o               sticky mul/div timeout (registered)
// Revision    : 1.0  initial release
// ============================================================================
interface ex_hazard_ctrl_if;
    logic [4:0] Rs1D_i;
    logic [4:0] Rs2D_i;
    logic [4:0] Rs1E_i;
    logic [4:0] Rs2E_i;
    logic [4:0] RdE_i;
    logic [4:0] RdM_i;
    logic [4:0] RdW_i;
    logic       RegWriteM_i;
    logic       RegWriteW_i;
    logic       LoadE_i;
    logic [1:0] PCSrcE_i;
    logic       MulDivE_i;
    logic       MulDivDone_i;
    logic [1:0] ForwardAE_o;
    logic [1:0] ForwardBE_o;
    logic       StallF_o;
    logic       StallD_o;
    logic       StallE_o;
    logic       FlushD_o;
    logic       FlushE_o;
    logic       FlushM_o;
    logic       MulDivStart_o;
    logic       Busy_o;
    logic       TimeoutErr_o;

    modport slave (
        input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
        input  RegWriteM_i, RegWriteW_i, LoadE_i, PCSrcE_i,
        input  MulDivE_i, MulDivDone_i,
        output ForwardAE_o, ForwardBE_o,
        output StallF_o, StallD_o, StallE_o,
        output FlushD_o, FlushE_o, FlushM_o,
        output MulDivStart_o, Busy_o, TimeoutErr_o
    );

    modport master (
        output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
        output RegWriteM_i, RegWriteW_i, LoadE_i, PCSrcE_i,
        output MulDivE_i, MulDivDone_i,
        input  ForwardAE_o, ForwardBE_o,
        input  StallF_o, StallD_o, StallE_o,
        input  FlushD_o, FlushE_o, FlushM_o,
        input  MulDivStart_o, Busy_o, TimeoutErr_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_hazard_ctrl
// Description : Central hazard controller for the 5-stage pipeline, wrapped
//               around the execute stage. Produces E-stage forwarding selects,
//               load-use and control-flow stall/flush controls, and sequences
//               the shared iterative mul/div unit (start pulse, pipeline hold
//               until done, timeout abort with sticky error).
// Parameters  : MD_TIMEOUT  max BUSY cycles before abort (>= 2)
// Ports       : clk            pipeline clock, rising edge
//               rst            asynchronous active-high reset
//               hz             ex_hazard_ctrl_if.slave (ids, status, controls)
//               StallCycles_o  [31:0] cycles with StallF_o high (optional)
//               FlushCount_o   [31:0] cycles with a taken branch/jump (optional)
// Options     : HAZARD_PERF_CNT_EN  adds the two saturating perf counters
// Revision    : 1.0  initial release
// ============================================================================
module ex_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64
) (
    input  wire         clk,
    input  wire         rst,
    ex_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles_o,
    output logic [31:0] FlushCount_o
`endif
);

    localparam int              c_CNT_W    = $clog2(MD_TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MD_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    // ------------------------------------------------------------------
    // Forwarding: M has the youngest value so it wins over W; x0 is
    // hard-wired zero and must never pick up a forwarded value.
    // ------------------------------------------------------------------
    logic [4:0] w_src_e [2];
    logic [1:0] w_fwd   [2];

    assign w_src_e[0] = hz.Rs1E_i;
    assign w_src_e[1] = hz.Rs2E_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign w_fwd[gi] =
            ((w_src_e[gi] != 5'd0) && hz.RegWriteM_i && (w_src_e[gi] == hz.RdM_i)) ? 2'b10 :
            ((w_src_e[gi] != 5'd0) && hz.RegWriteW_i && (w_src_e[gi] == hz.RdW_i)) ? 2'b01 :
                                                                                     2'b00;
    end

    assign hz.ForwardAE_o = w_fwd[0];
    assign hz.ForwardBE_o = w_fwd[1];

    // ------------------------------------------------------------------
    // Load-use and control-flow hazards
    // ------------------------------------------------------------------
    logic w_lw_stall;
    logic w_branch;
    logic w_lw_eff;

    assign w_lw_stall = hz.LoadE_i && (hz.RdE_i != 5'd0) &&
                        ((hz.Rs1D_i == hz.RdE_i) || (hz.Rs2D_i == hz.RdE_i));
    assign w_branch   = (hz.PCSrcE_i != 2'b00);
    // A taken branch squashes the dependent instruction in D anyway, so
    // the load-use hold is pointless in that cycle.
    assign w_lw_eff   = w_lw_stall && !w_branch;

    // ------------------------------------------------------------------
    // Mul/div sequencer
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               r_busy;
    logic               r_timeout_err;
    logic               w_md_start;
    logic               w_md_hold;
    logic               w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_busy        <= (w_state_nxt == c_ST_BUSY);
            r_timeout_err <= r_timeout_err | w_timeout;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_md_start  = 1'b0;
        w_md_hold   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_count_nxt = '0;
                if (hz.MulDivE_i) begin
                    w_md_start  = 1'b1;
                    w_md_hold   = 1'b1;
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                // Done is checked first so a result landing on the last
                // allowed cycle is accepted without raising the error.
                if (hz.MulDivDone_i) begin
                    w_state_nxt = c_ST_IDLE;
                    w_count_nxt = '0;
                end else if (r_count == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_md_hold   = 1'b1;
                    w_count_nxt = r_count + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
        // While reset is held the sequencer is idle; an E instruction
        // still flagged as mul/div must not start the unit until reset
        // is released.
        if (rst) begin
            w_md_start = 1'b0;
            w_md_hold  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stall / flush composition. A held E stage must keep its contents,
    // so FlushE is suppressed while the mul/div unit owns the pipeline.
    // ------------------------------------------------------------------
    logic w_stall_f;

    assign w_stall_f        = w_md_hold | w_lw_eff;
    assign hz.StallF_o      = w_stall_f;
    assign hz.StallD_o      = w_md_hold | w_lw_eff;
    assign hz.StallE_o      = w_md_hold;
    assign hz.FlushD_o      = w_branch;
    assign hz.FlushE_o      = !w_md_hold && (w_branch || w_lw_stall);
    assign hz.FlushM_o      = w_md_hold;
    assign hz.MulDivStart_o = w_md_start;
    assign hz.Busy_o        = r_busy;
    assign hz.TimeoutErr_o  = r_timeout_err;

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_f && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_branch && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign StallCycles_o = r_stall_cycles;
    assign FlushCount_o  = r_flush_count;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_hazard_ctrl
// Description : Self-checking bench for ex_hazard_ctrl. A cycle-level model
//               of the hazard rules is compared against every output on each
//               falling clock edge; directed scenarios add hand-computed
//               literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ex_hazard_ctrl;

    localparam int TB_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ex_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    ex_hazard_ctrl #(
        .MD_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles_o (stall_cycles),
        .FlushCount_o  (flush_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic        m_busy      = 1'b0;
    int          m_cycle     = 0;     // 1-based number of the current BUSY cycle
    logic        m_err       = 1'b0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    function automatic logic [1:0] exp_fwd(input logic [4:0] s);
        if (s == 5'd0)                              return 2'b00;
        if (hz.RegWriteM_i && s == hz.RdM_i)        return 2'b10;
        if (hz.RegWriteW_i && s == hz.RdW_i)        return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_lw();
        return hz.LoadE_i && hz.RdE_i != 5'd0 &&
               (hz.Rs1D_i == hz.RdE_i || hz.Rs2D_i == hz.RdE_i);
    endfunction

    function automatic logic exp_branch();
        return hz.PCSrcE_i != 2'b00;
    endfunction

    // Pipeline held for the mul/div unit: on the start cycle, and on every
    // BUSY cycle except the one where the result arrives or the budget of
    // TB_TIMEOUT BUSY cycles runs out.
    function automatic logic exp_hold();
        if (rst)                return 1'b0;
        if (!m_busy)            return hz.MulDivE_i;
        if (hz.MulDivDone_i)    return 1'b0;
        return m_cycle < TB_TIMEOUT;
    endfunction

    function automatic logic exp_start();
        return !rst && !m_busy && hz.MulDivE_i;
    endfunction

    function automatic logic exp_stall_fd();
        return exp_hold() || (exp_lw() && !exp_branch());
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy      <= 1'b0;
            m_cycle     <= 0;
            m_err       <= 1'b0;
            m_stall_cnt <= '0;
            m_flush_cnt <= '0;
        end else begin
            if (exp_stall_fd() && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt <= m_stall_cnt + 1;
            if (exp_branch()   && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt <= m_flush_cnt + 1;
            if (!m_busy) begin
                if (hz.MulDivE_i) begin
                    m_busy  <= 1'b1;
                    m_cycle <= 1;
                end
            end else if (hz.MulDivDone_i) begin
                m_busy <= 1'b0;
            end else if (m_cycle == TB_TIMEOUT) begin
                m_busy <= 1'b0;
                m_err  <= 1'b1;
            end else begin
                m_cycle <= m_cycle + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        check("ForwardAE",   hz.ForwardAE_o,   exp_fwd(hz.Rs1E_i));
        check("ForwardBE",   hz.ForwardBE_o,   exp_fwd(hz.Rs2E_i));
        check("StallF",      hz.StallF_o,      exp_stall_fd());
        check("StallD",      hz.StallD_o,      exp_stall_fd());
        check("StallE",      hz.StallE_o,      exp_hold());
        check("FlushD",      hz.FlushD_o,      exp_branch());
        check("FlushE",      hz.FlushE_o,      !exp_hold() && (exp_branch() || exp_lw()));
        check("FlushM",      hz.FlushM_o,      exp_hold());
        check("MulDivStart", hz.MulDivStart_o, exp_start());
        check("Busy",        hz.Busy_o,        m_busy);
        check("TimeoutErr",  hz.TimeoutErr_o,  m_err);
`ifdef HAZARD_PERF_CNT_EN
        check("StallCycles", stall_cycles,     m_stall_cnt);
        check("FlushCount",  flush_count,      m_flush_cnt);
`endif
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        hz.Rs1D_i       = '0;
        hz.Rs2D_i       = '0;
        hz.Rs1E_i       = '0;
        hz.Rs2E_i       = '0;
        hz.RdE_i        = '0;
        hz.RdM_i        = '0;
        hz.RdW_i        = '0;
        hz.RegWriteM_i  = 1'b0;
        hz.RegWriteW_i  = 1'b0;
        hz.LoadE_i      = 1'b0;
        hz.PCSrcE_i     = 2'b00;
        hz.MulDivE_i    = 1'b0;
        hz.MulDivDone_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_start;
        int n_stall;
        int n_busy;

        clear_inputs();
        rst = 1'b1;
        hz.MulDivE_i = 1'b1;          // must not start while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  hz.Busy_o,        1'b0);
        check("rst_err",   hz.TimeoutErr_o,  1'b0);
        check("rst_start", hz.MulDivStart_o, 1'b0);
        check("rst_stallF", hz.StallF_o,     1'b0);
        clear_inputs();
        #1;
        rst = 1'b0;
        step();

        // Forwarding
        hz.RdM_i = 5'd5; hz.RegWriteM_i = 1'b1;
        hz.RdW_i = 5'd5; hz.RegWriteW_i = 1'b1;
        hz.Rs1E_i = 5'd5;
        #1 check("fwdA_M_over_W", hz.ForwardAE_o, 2'b10);
        hz.Rs1E_i = 5'd0;
        #1 check("fwdA_x0", hz.ForwardAE_o, 2'b00);
        hz.RegWriteM_i = 1'b0; hz.Rs2E_i = 5'd5;
        #1 check("fwdB_W", hz.ForwardBE_o, 2'b01);
        hz.RdW_i = 5'd6;
        #1 check("fwdB_none", hz.ForwardBE_o, 2'b00);
        step();
        clear_inputs();

        // Load-use: one cycle only
        hz.LoadE_i = 1'b1; hz.RdE_i = 5'd7; hz.Rs2D_i = 5'd7;
        #1;
        check("lw_stallF", hz.StallF_o, 1'b1);
        check("lw_stallD", hz.StallD_o, 1'b1);
        check("lw_flushE", hz.FlushE_o, 1'b1);
        check("lw_stallE", hz.StallE_o, 1'b0);
        step();
        clear_inputs();
        #1;
        check("lw_next_stallF", hz.StallF_o, 1'b0);
        check("lw_next_flushE", hz.FlushE_o, 1'b0);
        hz.LoadE_i = 1'b1; hz.RdE_i = 5'd0;   // load into x0 never stalls
        #1 check("lw_x0_stallF", hz.StallF_o, 1'b0);
        step();
        clear_inputs();

        // Taken branch beats load-use
        hz.LoadE_i = 1'b1; hz.RdE_i = 5'd7; hz.Rs1D_i = 5'd7; hz.PCSrcE_i = 2'b01;
        #1;
        check("br_flushD", hz.FlushD_o, 1'b1);
        check("br_flushE", hz.FlushE_o, 1'b1);
        check("br_stallF", hz.StallF_o, 1'b0);
        step();
        clear_inputs();
        hz.PCSrcE_i = 2'b10;
        step();
        clear_inputs();
        step();

        // Mul/div with done in the 5th BUSY cycle
        n_start = 0; n_stall = 0; n_busy = 0;
        hz.MulDivE_i = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k == 5) hz.MulDivDone_i = 1'b1;
            @(negedge clk);
            n_start += int'(hz.MulDivStart_o);
            n_stall += int'(hz.StallE_o);
            n_busy  += int'(hz.Busy_o);
            step();
            if (k == 5) begin
                hz.MulDivE_i    = 1'b0;
                hz.MulDivDone_i = 1'b0;
            end
        end
        check("md_start_pulses", n_start, 1);
        check("md_stallE_cycles", n_stall, 5);
        check("md_busy_cycles", n_busy, 5);
        check("md_no_err", hz.TimeoutErr_o, 1'b0);

        // Mul/div timeout
        n_stall = 0; n_busy = 0;
        hz.MulDivE_i = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            n_stall += int'(hz.StallE_o);
            n_busy  += int'(hz.Busy_o);
            if (k == 8) check("to_last_stallE", hz.StallE_o, 1'b0);
            step();
            if (k == 8) hz.MulDivE_i = 1'b0;
        end
        check("to_busy_cycles", n_busy, TB_TIMEOUT);
        check("to_stall_cycles", n_stall, TB_TIMEOUT);
        check("to_err", hz.TimeoutErr_o, 1'b1);
        check("to_idle", hz.Busy_o, 1'b0);
        check("to_stallF", hz.StallF_o, 1'b0);

        // Reset in BUSY cycle 3
        hz.MulDivE_i = 1'b1;
        step(); step(); step();
        check("rb_busy_before", hz.Busy_o, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rb_busy", hz.Busy_o, 1'b0);
        check("rb_stallE", hz.StallE_o, 1'b0);
        check("rb_stallF", hz.StallF_o, 1'b0);
        check("rb_start", hz.MulDivStart_o, 1'b0);
        check("rb_err_cleared", hz.TimeoutErr_o, 1'b0);
        step();
        rst = 1'b0;
        #1 check("rb_restart", hz.MulDivStart_o, 1'b1);
        step();
        hz.MulDivDone_i = 1'b1;
        step();
        clear_inputs();
        #1 check("rb_done_idle", hz.Busy_o, 1'b0);
        step();

        // Done and timeout on the same cycle: done wins
        hz.MulDivE_i = 1'b1;
        for (int k = 0; k < TB_TIMEOUT; k++) step();
        hz.MulDivDone_i = 1'b1;
        #1 check("dt_stallE", hz.StallE_o, 1'b0);
        step();
        clear_inputs();
        #1;
        check("dt_no_err", hz.TimeoutErr_o, 1'b0);
        check("dt_idle", hz.Busy_o, 1'b0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
